// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned HDR_BYTES = 2;
  localparam int unsigned LANES     = 4;
  localparam int unsigned LANE_W    = $clog2(LANES);
  localparam int unsigned WORD_W    = LANES * BYTE_W;
  localparam int unsigned LEN_W     = HDR_BYTES * BYTE_W;
  localparam int unsigned ADDR_W    = 32;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and RAM write port of the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic                in_valid;
  logic [BYTE_W-1:0]   in_data;
  logic                in_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WORD_W-1:0]   wr_data;
  logic [LANES-1:0]    wr_strb;

  // Loader side: consumes the stream, drives the RAM write port.
  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, wr_strb
  );

  // Host/RAM side.
  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, wr_strb
  );
endinterface

// File: rtl/imem_word_packer.sv
// Packs bytes into little-endian words and emits one registered write per flush.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              take,
  input  logic [BYTE_W-1:0] data,
  input  logic [LANE_W-1:0] lane,
  input  logic              flush,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_data,
  output logic [LANES-1:0]  wr_strb
);

  logic [WORD_W-1:0] pack_q;
  logic [LANES-1:0]  strb_q;
  logic [WORD_W-1:0] merged_data;
  logic [LANES-1:0]  merged_strb;

  // Current buffer with the incoming byte dropped into its lane.
  always_comb begin
    merged_data = pack_q;
    merged_data[int'(lane)*BYTE_W +: BYTE_W] = data;
    merged_strb = strb_q | (LANES'(1) << lane);
  end

  // Accumulate lanes; on flush publish the word and clear the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q  <= '0;
      strb_q  <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
      wr_strb <= '0;
    end else begin
      wr_en <= 1'b0;
      if (take) begin
        if (flush) begin
          wr_en   <= 1'b1;
          wr_data <= merged_data;
          wr_strb <= merged_strb;
          pack_q  <= '0;
          strb_q  <= '0;
        end else begin
          pack_q <= merged_data;
          strb_q <= merged_strb;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-store loader: length-prefixed byte stream -> 32-bit RAM writes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold,
  output logic [LEN_W-1:0]  bytes_loaded
);

  localparam int unsigned   CAP_BYTES = DEPTH * LANES;
  localparam logic [LEN_W:0] CAP      = (LEN_W+1)'(CAP_BYTES);

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic               xfer;
  logic               take;
  logic               last;
  logic               flush;
  logic [LANE_W-1:0]  lane;
  logic [LEN_W-1:0]   hdr_len;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]  csum_q;
`endif

  // Transfer qualifiers for the current cycle.
  always_comb begin
    xfer    = bus.in_valid && bus.in_ready;
    take    = xfer && (state == DATA);
    lane    = bytes_loaded[LANE_W-1:0];
    last    = (bytes_loaded == (len_q - LEN_W'(1)));
    flush   = (lane == LANE_W'(LANES - 1)) || last;
    hdr_len = {bus.in_data, len_q[BYTE_W-1:0]};
  end

  imem_word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .take    (take),
    .data    (bus.in_data),
    .lane    (lane),
    .flush   (flush),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .wr_strb (bus.wr_strb)
  );

  // Load sequencer with registered handshake, status and address outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len_q        <= '0;
      bytes_loaded <= '0;
      bus.in_ready <= 1'b0;
      bus.wr_addr  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      cpu_hold     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR0;
            len_q        <= '0;
            bytes_loaded <= '0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            err          <= 1'b0;
          end
        end
        HDR0: begin
          if (xfer) begin
            len_q[BYTE_W-1:0] <= bus.in_data;
            state             <= HDR1;
`ifdef LOADER_CHECKSUM_EN
            csum_q            <= bus.in_data;
`endif
          end
        end
        HDR1: begin
          if (xfer) begin
            len_q[LEN_W-1:BYTE_W] <= bus.in_data;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.in_data;
`endif
            if ({1'b0, hdr_len} > CAP) begin
              state        <= ERR;
              err          <= 1'b1;
              busy         <= 1'b0;
              cpu_hold     <= 1'b0;
              bus.in_ready <= 1'b0;
            end else if (hdr_len == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state        <= CSUM;
`else
              state        <= DONE;
              done         <= 1'b1;
              busy         <= 1'b0;
              cpu_hold     <= 1'b0;
              bus.in_ready <= 1'b0;
`endif
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            bytes_loaded <= bytes_loaded + LEN_W'(1);
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.in_data;
`endif
            if (flush) begin
              bus.wr_addr <= BASE_ADDR + ADDR_W'({bytes_loaded[LEN_W-1:LANE_W], LANE_W'(0)});
            end
            if (last) begin
`ifdef LOADER_CHECKSUM_EN
              state        <= CSUM;
`else
              state        <= DONE;
              done         <= 1'b1;
              busy         <= 1'b0;
              cpu_hold     <= 1'b0;
              bus.in_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            busy         <= 1'b0;
            cpu_hold     <= 1'b0;
            bus.in_ready <= 1'b0;
            if ((csum_q ^ bus.in_data) == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          cpu_hold     <= 1'b0;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; honours LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, err, cpu_hold;
  logic [15:0] bytes_loaded;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .cpu_hold     (cpu_hold),
    .bytes_loaded (bytes_loaded)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] ws_q[$];
  int          wc_q[$];
  int          done_cnt;
  int          payload_acc;
  logic [7:0]  pl[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      ws_q.push_back(32'(bus.wr_strb));
      wc_q.push_back(payload_acc);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); ws_q.delete(); wc_q.delete();
    done_cnt    = 0;
    payload_acc = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit payload, input bit gaps);
    bit ok = 1'b0;
    if (gaps) begin
      int n = int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        @(negedge clk); bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("ready_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
    end else if (payload) begin
      payload_acc++;
    end
  endtask

  // Full load of the global payload pl; csum < 0 means send the correct XOR.
  task automatic load(input logic [15:0] len, input bit gaps, input int csum);
    logic [7:0] x;
    x = len[7:0] ^ len[15:8];
    pulse_start();
    send_byte(len[7:0], 1'b0, gaps);
    send_byte(len[15:8], 1'b0, gaps);
    foreach (pl[i]) begin
      send_byte(pl[i], 1'b1, gaps);
      x = x ^ pl[i];
    end
`ifdef LOADER_CHECKSUM_EN
    if (len <= 16'd1024) send_byte((csum < 0) ? x : 8'(csum), 1'b0, gaps);
`else
    if (csum > 1000) x = 8'h00;
`endif
    @(negedge clk); bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_wr(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] s);
    if (i < wa_q.size()) begin
      check($sformatf("wr%0d_addr", i), wa_q[i], a);
      check($sformatf("wr%0d_data", i), wd_q[i], d);
      check($sformatf("wr%0d_strb", i), ws_q[i], s);
    end else begin
      check($sformatf("wr%0d_missing", i), 32'd0, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_bytes", 32'(bytes_loaded), 32'd0);
    rst = 1'b0;

    // 1: two full words.
    clear_mon();
    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    load(16'd8, 1'b0, -1);
    check("t1_nwr", 32'(wa_q.size()), 32'd2);
    check_wr(0, 32'h0, 32'h0000_0013, 32'hF);
    check_wr(1, 32'h4, 32'h0010_0093, 32'hF);
    check("t1_done", 32'(done_cnt), 32'd1);
    check("t1_bytes", 32'(bytes_loaded), 32'd8);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: partial final word.
    clear_mon();
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    load(16'd5, 1'b0, -1);
    check("t2_nwr", 32'(wa_q.size()), 32'd2);
    check_wr(0, 32'h0, 32'h4433_2211, 32'hF);
    check_wr(1, 32'h4, 32'h0000_0055, 32'h1);
    check("t2_bytes", 32'(bytes_loaded), 32'd5);

    // 3: oversize length.
    clear_mon();
    pl.delete();
    load(16'd1025, 1'b0, -1);
    check("t3_err", 32'(err), 32'd1);
    check("t3_nwr", 32'(wa_q.size()), 32'd0);
    check("t3_ready", 32'(bus.in_ready), 32'd0);
    check("t3_hold", 32'(cpu_hold), 32'd0);
    check("t3_done", 32'(done_cnt), 32'd0);

    // 4: stalls on in_valid, recovering from ERR.
    clear_mon();
    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    load(16'd8, 1'b1, -1);
    check("t4_err", 32'(err), 32'd0);
    check("t4_nwr", 32'(wa_q.size()), 32'd2);
    check_wr(0, 32'h0, 32'h0000_0013, 32'hF);
    check_wr(1, 32'h4, 32'h0010_0093, 32'hF);
    if (wc_q.size() == 2) begin
      check("t4_wr0_after", 32'(wc_q[0]), 32'd4);
      check("t4_wr1_after", 32'(wc_q[1]), 32'd8);
    end
    check("t4_done", 32'(done_cnt), 32'd1);

    // 5: reset mid-load, then a clean load.
    clear_mon();
    pulse_start();
    send_byte(8'h08, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hA1, 1'b1, 1'b0);
    send_byte(8'hA2, 1'b1, 1'b0);
    send_byte(8'hA3, 1'b1, 1'b0);
    @(negedge clk); bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t5_ready", 32'(bus.in_ready), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_hold", 32'(cpu_hold), 32'd0);
    check("t5_bytes", 32'(bytes_loaded), 32'd0);
    check("t5_wr_en", 32'(bus.wr_en), 32'd0);
    check("t5_wr_data", bus.wr_data, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_nwr_abort", 32'(wa_q.size()), 32'd0);
    clear_mon();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    load(16'd4, 1'b0, -1);
    check("t5_nwr", 32'(wa_q.size()), 32'd1);
    check_wr(0, 32'h0, 32'h0403_0201, 32'hF);
    check("t5_done", 32'(done_cnt), 32'd1);

    // Zero length: done with no write.
    clear_mon();
    pl.delete();
    load(16'd0, 1'b0, -1);
    check("t0_nwr", 32'(wa_q.size()), 32'd0);
    check("t0_done", 32'(done_cnt), 32'd1);
    check("t0_err", 32'(err), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum match and mismatch.
    clear_mon();
    pl = '{8'hAB};
    load(16'd1, 1'b0, 8'hAA);
    check("t6_done", 32'(done_cnt), 32'd1);
    check("t6_err", 32'(err), 32'd0);
    check_wr(0, 32'h0, 32'h0000_00AB, 32'h1);
    clear_mon();
    load(16'd1, 1'b0, 8'h00);
    check("t6b_err", 32'(err), 32'd1);
    check("t6b_done", 32'(done_cnt), 32'd0);
    check("t6b_nwr", 32'(wa_q.size()), 32'd1);
    check("t6b_hold", 32'(cpu_hold), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
